// File: rtl/hazard_pkg.sv
// Shared constants, scoreboard entry type and helpers for the MIPS hazard tracker.
package hazard_pkg;

    localparam int unsigned SB_AW = 5;
    localparam int unsigned SB_TW = 2;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_W  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_E  = 2'd3;

    localparam logic [SB_TW-1:0] TUSE_NONE = SB_TW'(3);
    localparam logic [SB_TW-1:0] TNEW_JAL  = SB_TW'(0);
    localparam logic [SB_TW-1:0] TNEW_ALU  = SB_TW'(1);
    localparam logic [SB_TW-1:0] TNEW_LD   = SB_TW'(2);

    typedef struct packed {
        logic [SB_AW-1:0] a3;
        logic [SB_TW-1:0] tnew;
        logic             wr;
    } sb_entry_t;

    // Tnew ages by one per stage and saturates at zero.
    function automatic logic [SB_TW-1:0] tnew_dec(input logic [SB_TW-1:0] t);
        return (t == '0) ? '0 : t - SB_TW'(1);
    endfunction

    // $0 writers are never live.
    function automatic logic entry_live(input sb_entry_t e);
        return e.wr && (e.a3 != '0);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward select for one operand: youngest eligible stage wins (E, then M, then W).
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [SB_AW-1:0] addr_i,
    input  logic             e_en_i,
    input  sb_entry_t        ent_e_i,
    input  sb_entry_t        ent_m_i,
    input  sb_entry_t        ent_w_i,
    output logic [1:0]       sel_c_o
);

    function automatic logic eligible(input sb_entry_t e, input logic [SB_AW-1:0] a);
        return entry_live(e) && (e.a3 == a) && (e.tnew == '0);
    endfunction

    always_comb begin
        sel_c_o = FWD_RF;
        if (e_en_i && eligible(ent_e_i, addr_i)) begin
            sel_c_o = FWD_E;
        end else if (eligible(ent_m_i, addr_i)) begin
            sel_c_o = FWD_M;
        end else if (eligible(ent_w_i, addr_i)) begin
            sel_c_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// E/M/W writer scoreboard producing the D-stage stall and D/E/M forwarding selects.
module hazard_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned T_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] A1_D,
    input  logic [REG_AW-1:0] A2_D,
    input  logic [T_W-1:0]    TuseRs_D,
    input  logic [T_W-1:0]    TuseRt_D,
    input  logic [REG_AW-1:0] A3_D,
    input  logic              RegWrite_D,
    input  logic [T_W-1:0]    TnewD,
    output logic              Stall,
    output logic [1:0]        FwdRs_D,
    output logic [1:0]        FwdRt_D,
    output logic [1:0]        FwdRs_E,
    output logic [1:0]        FwdRt_E,
    output logic              FwdRt_M
);

    sb_entry_t        e_q, e_d;
    sb_entry_t        m_q, m_d;
    sb_entry_t        w_q, w_d;
    logic [SB_AW-1:0] a1_e_q, a1_e_d;
    logic [SB_AW-1:0] a2_e_q, a2_e_d;
    logic [SB_AW-1:0] a2_m_q, a2_m_d;

    logic [SB_AW-1:0] a1_d_c, a2_d_c, a3_d_c;
    logic [SB_TW-1:0] tuse_rs_c, tuse_rt_c, tnew_d_c;
    logic             stall_c;

    assign a1_d_c    = SB_AW'(A1_D);
    assign a2_d_c    = SB_AW'(A2_D);
    assign a3_d_c    = SB_AW'(A3_D);
    assign tuse_rs_c = SB_TW'(TuseRs_D);
    assign tuse_rt_c = SB_TW'(TuseRt_D);
    assign tnew_d_c  = SB_TW'(TnewD);

    // A reader stalls while a live E/M writer's result is not ready by its Tuse.
    function automatic logic operand_hazard(input logic [SB_AW-1:0] a,
                                            input logic [SB_TW-1:0] tuse,
                                            input sb_entry_t        e,
                                            input sb_entry_t        m);
        logic he, hm;
        he = entry_live(e) && (e.a3 == a) && (tuse < e.tnew);
        hm = entry_live(m) && (m.a3 == a) && (tuse < m.tnew);
        return (a != '0) && (tuse != TUSE_NONE) && (he || hm);
    endfunction

    assign stall_c = operand_hazard(a1_d_c, tuse_rs_c, e_q, m_q)
                   | operand_hazard(a2_d_c, tuse_rt_c, e_q, m_q);
    assign Stall   = stall_c;

    always_comb begin
        e_d      = '0;
        e_d.a3   = a3_d_c;
        e_d.tnew = tnew_d_c;
        e_d.wr   = RegWrite_D;
        a1_e_d   = a1_d_c;
        a2_e_d   = a2_d_c;
        if (stall_c) begin
            e_d    = '0;
            a1_e_d = '0;
            a2_e_d = '0;
        end
        m_d      = '0;
        m_d.a3   = e_q.a3;
        m_d.tnew = tnew_dec(e_q.tnew);
        m_d.wr   = e_q.wr;
        a2_m_d   = a2_e_q;
        w_d      = '0;
        w_d.a3   = m_q.a3;
        w_d.tnew = tnew_dec(m_q.tnew);
        w_d.wr   = m_q.wr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q    <= '0;
            m_q    <= '0;
            w_q    <= '0;
            a1_e_q <= '0;
            a2_e_q <= '0;
            a2_m_q <= '0;
        end else begin
            e_q    <= e_d;
            m_q    <= m_d;
            w_q    <= w_d;
            a1_e_q <= a1_e_d;
            a2_e_q <= a2_e_d;
            a2_m_q <= a2_m_d;
        end
    end

    hazard_fwd_sel u_sel_rs_d (
        .addr_i (a1_d_c),
        .e_en_i (1'b1),
        .ent_e_i(e_q),
        .ent_m_i(m_q),
        .ent_w_i(w_q),
        .sel_c_o(FwdRs_D)
    );

    hazard_fwd_sel u_sel_rt_d (
        .addr_i (a2_d_c),
        .e_en_i (1'b1),
        .ent_e_i(e_q),
        .ent_m_i(m_q),
        .ent_w_i(w_q),
        .sel_c_o(FwdRt_D)
    );

    // E operands never forward from E itself.
    hazard_fwd_sel u_sel_rs_e (
        .addr_i (a1_e_q),
        .e_en_i (1'b0),
        .ent_e_i('0),
        .ent_m_i(m_q),
        .ent_w_i(w_q),
        .sel_c_o(FwdRs_E)
    );

    hazard_fwd_sel u_sel_rt_e (
        .addr_i (a2_e_q),
        .e_en_i (1'b0),
        .ent_e_i('0),
        .ent_m_i(m_q),
        .ent_w_i(w_q),
        .sel_c_o(FwdRt_E)
    );

    assign FwdRt_M = (a2_m_q != '0) && entry_live(w_q) && (w_q.a3 == a2_m_q);

endmodule
